// File: rtl/disp_mode_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// disp_mode_ctrl_pkg
// Shared types and constants for the display mode controller.
//   disp_state_e : controller FSM states
//   VIEW_*       : codes driven on the 'view' output
//   DASH_CODE    : digit code the scan driver renders as a dash
//   view_of()    : view code shown for a given state
//   is_edit()    : true in either edit state
// -----------------------------------------------------------------------------
package disp_mode_ctrl_pkg;

  typedef enum logic [2:0] {
    SHOW_TIME  = 3'd0,
    SHOW_ALARM = 3'd1,
    SHOW_SW    = 3'd2,
    EDIT_TIME  = 3'd3,
    EDIT_ALARM = 3'd4
  } disp_state_e;

  localparam logic [1:0] VIEW_TIME  = 2'd0;
  localparam logic [1:0] VIEW_ALARM = 2'd1;
  localparam logic [1:0] VIEW_SW    = 2'd2;

  localparam logic [3:0] DASH_CODE = 4'hF;

  function automatic logic [1:0] view_of(input disp_state_e s);
    logic [1:0] v;
    case (s)
      SHOW_ALARM, EDIT_ALARM: v = VIEW_ALARM;
      SHOW_SW:                v = VIEW_SW;
      default:                v = VIEW_TIME;
    endcase
    return v;
  endfunction

  function automatic logic is_edit(input disp_state_e s);
    return (s == EDIT_TIME) || (s == EDIT_ALARM);
  endfunction

endpackage

// File: rtl/disp_mode_ctrl_blink_gen.sv
// -----------------------------------------------------------------------------
// blink_gen
// Blink phase generator for the digit being edited. While en is high the
// counter runs 0..BLINK_HALF and the phase bit toggles each time it wraps,
// i.e. every BLINK_HALF+1 cycles. clr (or en low) restarts with phase 0.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   clr   in  restart counter and phase
//   en    in  count enable
//   phase out current blink phase (1 = digit hidden)
// -----------------------------------------------------------------------------
module blink_gen #(
  parameter int BLINK_HALF = 12499999
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic phase
);

  localparam int CW = (BLINK_HALF > 0) ? $clog2(BLINK_HALF + 1) : 1;
  localparam logic [CW-1:0] HALF_V = CW'(BLINK_HALF);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == HALF_V) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/disp_mode_ctrl.sv
// -----------------------------------------------------------------------------
// disp_mode_ctrl
// Display mode controller for a clock/alarm/stopwatch display. Buttons cycle
// the view or edit time/alarm digits; the edited digit blinks.
// Optional feature: define DISP_TIMEOUT_EN to return to SHOW_TIME after
// TIMEOUT+1 cycles without a button press.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   btn_mode/btn_set/btn_up  one-cycle button pulses (priority mode>set>up)
//   time_dig/alarm_dig/sw_dig 16-bit BCD digit sources, [15:12] leftmost
//   data1..data4             registered digit codes, data1 leftmost
//   view                     0 TIME, 1 ALARM, 2 SW
//   edit_active              registered, high in an edit state
//   inc_time/inc_alarm       one-cycle increment requests, qualified by inc_pos
//   dbg_state                current FSM state for observation
// Handshake: buttons are fire-and-forget pulses with no ready; inc_* pulses
// are single-cycle requests the consumer must accept unconditionally.
// -----------------------------------------------------------------------------
module disp_mode_ctrl
  import disp_mode_ctrl_pkg::*;
#(
  parameter int BLINK_HALF = 12499999,
  parameter int TIMEOUT    = 499999999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_set,
  input  logic        btn_up,
  input  logic [15:0] time_dig,
  input  logic [15:0] alarm_dig,
  input  logic [15:0] sw_dig,
  output logic [3:0]  data1,
  output logic [3:0]  data2,
  output logic [3:0]  data3,
  output logic [3:0]  data4,
  output logic [1:0]  view,
  output logic        edit_active,
  output logic        inc_time,
  output logic        inc_alarm,
  output logic [1:0]  inc_pos,
  output disp_state_e dbg_state
);

  disp_state_e state_q, state_d;
  logic [1:0]  pos_q, pos_d;
  logic        inc_t_d, inc_a_d;
  logic        any_btn;
  logic        timeout_hit;
  logic        blink_clr;
  logic        blink_phase;
  logic        blank;
  logic [15:0] src;

  assign any_btn   = btn_mode | btn_set | btn_up;
  assign dbg_state = state_q;

`ifdef DISP_TIMEOUT_EN
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] TIMEOUT_V = IW'(TIMEOUT);

  logic [IW-1:0] idle_q;

  // Button wins over a timeout landing in the same cycle.
  assign timeout_hit = (idle_q == TIMEOUT_V) && (state_q != SHOW_TIME) && !any_btn;

  always_ff @(posedge clk) begin
    if (rst || any_btn || (state_d == SHOW_TIME)) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + IW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic; the button chain gives mode > set > up.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    inc_t_d = 1'b0;
    inc_a_d = 1'b0;
    case (state_q)
      SHOW_TIME: begin
        if (btn_mode) begin
          state_d = SHOW_ALARM;
        end else if (btn_set) begin
          state_d = EDIT_TIME;
          pos_d   = 2'd0;
        end
      end
      SHOW_ALARM: begin
        if (btn_mode) begin
          state_d = SHOW_SW;
        end else if (btn_set) begin
          state_d = EDIT_ALARM;
          pos_d   = 2'd0;
        end
      end
      SHOW_SW: begin
        if (btn_mode) begin
          state_d = SHOW_TIME;
        end
      end
      EDIT_TIME, EDIT_ALARM: begin
        if (btn_mode) begin
          state_d = (state_q == EDIT_TIME) ? SHOW_TIME : SHOW_ALARM;
        end else if (btn_set) begin
          if (pos_q == 2'd3) begin
            state_d = (state_q == EDIT_TIME) ? SHOW_TIME : SHOW_ALARM;
          end else begin
            pos_d = pos_q + 2'd1;
          end
        end else if (btn_up) begin
          inc_t_d = (state_q == EDIT_TIME);
          inc_a_d = (state_q == EDIT_ALARM);
        end
      end
      default: begin
        state_d = SHOW_TIME;
      end
    endcase
    if (timeout_hit) begin
      state_d = SHOW_TIME;
      pos_d   = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SHOW_TIME;
      pos_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
    end
  end

  assign blink_clr = any_btn || (is_edit(state_d) && !is_edit(state_q));

  blink_gen #(
    .BLINK_HALF (BLINK_HALF)
  ) u_blink (
    .clk   (clk),
    .rst   (rst),
    .clr   (blink_clr),
    .en    (is_edit(state_q)),
    .phase (blink_phase)
  );

  // Outputs are built from the next state so they line up with the state
  // register. A press forces the digit visible in the same update.
  always_comb begin
    case (view_of(state_d))
      VIEW_ALARM: src = alarm_dig;
      VIEW_SW:    src = sw_dig;
      default:    src = time_dig;
    endcase
  end

  assign blank = is_edit(state_d) && blink_phase && !blink_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      data1       <= 4'd0;
      data2       <= 4'd0;
      data3       <= 4'd0;
      data4       <= 4'd0;
      view        <= VIEW_TIME;
      edit_active <= 1'b0;
      inc_time    <= 1'b0;
      inc_alarm   <= 1'b0;
      inc_pos     <= 2'd0;
    end else begin
      data1       <= (blank && pos_d == 2'd0) ? DASH_CODE : src[15:12];
      data2       <= (blank && pos_d == 2'd1) ? DASH_CODE : src[11:8];
      data3       <= (blank && pos_d == 2'd2) ? DASH_CODE : src[7:4];
      data4       <= (blank && pos_d == 2'd3) ? DASH_CODE : src[3:0];
      view        <= view_of(state_d);
      edit_active <= is_edit(state_d);
      inc_time    <= inc_t_d;
      inc_alarm   <= inc_a_d;
      inc_pos     <= pos_q;
    end
  end

endmodule

// File: tb/tb_disp_mode_ctrl.sv
module tb_disp_mode_ctrl;
  import disp_mode_ctrl_pkg::*;

  localparam int BH = 3;
  localparam int TO = 9;

  // clock/reset block
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        btn_mode = 1'b0, btn_set = 1'b0, btn_up = 1'b0;
  logic [15:0] time_dig = 16'h1234, alarm_dig = 16'h0630, sw_dig = 16'h5907;
  logic [3:0]  data1, data2, data3, data4;
  logic [1:0]  view, inc_pos;
  logic        edit_active, inc_time, inc_alarm;
  disp_state_e dbg_state;

  disp_mode_ctrl #(.BLINK_HALF(BH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_set(btn_set), .btn_up(btn_up),
    .time_dig(time_dig), .alarm_dig(alarm_dig), .sw_dig(sw_dig),
    .data1(data1), .data2(data2), .data3(data3), .data4(data4),
    .view(view), .edit_active(edit_active), .inc_time(inc_time),
    .inc_alarm(inc_alarm), .inc_pos(inc_pos), .dbg_state(dbg_state)
  );

  int passes = 0;
  int total  = 0;

  // Reference model: which view, whether editing, edited digit, cycles since
  // the last press and idle cycles outside SHOW_TIME.
  int   m_view = 0;
  bit   m_edit = 0;
  int   m_pos  = 0;
  int   m_since = 0;
  int   m_idle = 0;
  logic [3:0] e_data [4];
  logic [1:0] e_view = 0;
  logic       e_edit = 0, e_it = 0, e_ia = 0;
  logic [1:0] e_ipos = 0;
  bit         e_ipos_chk = 1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [15:0] bcd4();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit any_btn;
    logic [15:0] src;
    any_btn = btn_mode | btn_set | btn_up;
    if (rst) begin
      m_view = 0; m_edit = 0; m_pos = 0; m_since = 0; m_idle = 0;
      e_it = 0; e_ia = 0; e_ipos = 0; e_ipos_chk = 1;
      e_view = 0; e_edit = 0;
      for (int i = 0; i < 4; i++) e_data[i] = 4'd0;
      return;
    end
    e_it = m_edit && (m_view == 0) && btn_up && !btn_mode && !btn_set;
    e_ia = m_edit && (m_view == 1) && btn_up && !btn_mode && !btn_set;
    e_ipos = 2'(m_pos);
    e_ipos_chk = e_it || e_ia;
    if (btn_mode) begin
      if (m_edit) m_edit = 0;
      else m_view = (m_view + 1) % 3;
    end else if (btn_set) begin
      if (m_edit) begin
        if (m_pos == 3) m_edit = 0;
        else m_pos++;
      end else if (m_view != 2) begin
        m_edit = 1; m_pos = 0;
      end
    end
    if (any_btn) m_since = 0;
    else m_since++;
`ifdef DISP_TIMEOUT_EN
    if (any_btn) m_idle = 0;
    else if (!(m_view == 0 && !m_edit)) begin
      m_idle++;
      if (m_idle == TO + 1) begin
        m_view = 0; m_edit = 0; m_idle = 0;
      end
    end
`endif
    src = (m_view == 0) ? time_dig : (m_view == 1) ? alarm_dig : sw_dig;
    for (int i = 0; i < 4; i++) begin
      e_data[i] = src[15 - 4*i -: 4];
      if (m_edit && i == m_pos && m_since >= 1 && ((m_since - 1) / (BH + 1)) % 2 == 1)
        e_data[i] = 4'hF;
    end
    e_view = 2'(m_view);
    e_edit = m_edit;
  endtask

  // driver tasks
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    btn_mode = 1'b0; btn_set = 1'b0; btn_up = 1'b0; rst = 1'b0;
  endtask

  task automatic check_all();
    chk("data1", 16'(data1), 16'(e_data[0]));
    chk("data2", 16'(data2), 16'(e_data[1]));
    chk("data3", 16'(data3), 16'(e_data[2]));
    chk("data4", 16'(data4), 16'(e_data[3]));
    chk("view", 16'(view), 16'(e_view));
    chk("edit_active", 16'(edit_active), 16'(e_edit));
    chk("inc_time", 16'(inc_time), 16'(e_it));
    chk("inc_alarm", 16'(inc_alarm), 16'(e_ia));
    if (e_ipos_chk) chk("inc_pos", 16'(inc_pos), 16'(e_ipos));
  endtask

  task automatic press(input bit m, input bit s, input bit u);
    btn_mode = m; btn_set = s; btn_up = u;
    tick();
    check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      check_all();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check_all();
  endtask

  initial begin
    // reset state, with buttons held to confirm reset wins
    btn_mode = 1'b1; btn_set = 1'b1; btn_up = 1'b1;
    do_reset();
    chk("rst_data1", 16'(data1), 16'h0);
    chk("rst_state", 16'(dbg_state), 16'(SHOW_TIME));
    chk("rst_inc_pos", 16'(inc_pos), 16'h0);

    // scenario 1: view cycling with data tracking each source
    time_dig = 16'h1234;
    idle(1);
    chk("s1_time", {data1, data2, data3, data4}, 16'h1234);
    press(1, 0, 0);
    chk("s1_view1", 16'(view), 16'd1);
    chk("s1_alarm", {data1, data2, data3, data4}, alarm_dig);
    press(1, 0, 0);
    chk("s1_view2", 16'(view), 16'd2);
    chk("s1_sw", {data1, data2, data3, data4}, sw_dig);
    press(0, 1, 0);
    chk("s1_set_ignored_sw", 16'(edit_active), 16'd0);
    press(1, 0, 0);
    chk("s1_view0", 16'(view), 16'd0);

    // scenario 2: edit time, increment digit 0
    press(0, 1, 0);
    chk("s2_edit", 16'(edit_active), 16'd1);
    press(0, 0, 1);
    chk("s2_inc_time", 16'(inc_time), 16'd1);
    chk("s2_inc_pos", 16'(inc_pos), 16'd0);
    chk("s2_inc_alarm", 16'(inc_alarm), 16'd0);
    idle(1);
    chk("s2_inc_one_cycle", 16'(inc_time), 16'd0);

    // scenario 3: blink on digit 2 of 1234
    press(0, 1, 0);
    press(0, 1, 0);
    idle(4);
    chk("s3_visible", {data1, data2, data3, data4}, 16'h1234);
    idle(4);
    chk("s3_dash", {data1, data2, data3, data4}, 16'h12F4);
    press(0, 0, 1);
    chk("s3_visible_after_press", 16'(data3), 16'h3);
    chk("s3_inc_pos2", 16'(inc_pos), 16'd2);
    press(1, 0, 0);
    chk("s3_abort", 16'(edit_active), 16'd0);

    // scenario 4: mode and set together
    do_reset();
    press(1, 1, 0);
    chk("s4_view", 16'(view), 16'd1);
    chk("s4_edit", 16'(edit_active), 16'd0);

    // scenario 5: finish alarm edit, then btn_up does nothing
    press(0, 1, 0);
    press(0, 0, 1);
    chk("s5_inc_alarm", 16'(inc_alarm), 16'd1);
    press(0, 1, 0);
    press(0, 1, 0);
    press(0, 1, 0);
    press(0, 1, 0);
    chk("s5_exit_edit", 16'(edit_active), 16'd0);
    chk("s5_exit_view", 16'(view), 16'd1);
    press(0, 0, 1);
    chk("s5_no_inc", 16'(inc_alarm | inc_time), 16'd0);

    // reset during edit drops a pending increment
    do_reset();
    press(0, 1, 0);
    btn_up = 1'b1;
    do_reset();
    chk("rst_drops_inc", 16'(inc_time), 16'd0);

    // scenario 6: idle in EDIT_ALARM
    press(1, 0, 0);
    press(0, 1, 0);
`ifdef DISP_TIMEOUT_EN
    idle(9);
    chk("s6_still_edit", 16'(edit_active), 16'd1);
    idle(1);
    chk("s6_timeout_view", 16'(view), 16'd0);
    chk("s6_timeout_edit", 16'(edit_active), 16'd0);
`else
    idle(1000);
    chk("s6_persist_view", 16'(view), 16'd1);
    chk("s6_persist_edit", 16'(edit_active), 16'd1);
`endif

    // randomized stimulus against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        time_dig = bcd4(); alarm_dig = bcd4(); sw_dig = bcd4();
      end
      rst      = ($urandom_range(0, 79) == 0);
      btn_mode = ($urandom_range(0, 6) == 0);
      btn_set  = ($urandom_range(0, 3) == 0);
      btn_up   = ($urandom_range(0, 3) == 0);
      tick();
      check_all();
      if (i % 60 == 30) idle($urandom_range(5, 14));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
